// File: rtl/spi_load_sequencer_pkg.sv
// Shared widths, cache sizes, FSM encoding and the per-target address range check
// for the SPI cache loader.
package spi_load_sequencer_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int FRAME_W = DATA_W + ADDR_W;
  localparam int IMEM_SZ = 16;
  localparam int DMEM_SZ = 9;
  localparam int CNT_W   = 4;
  localparam int FCNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT_I = 2'b01,
    ST_SHIFT_D = 2'b10,
    ST_ABORT   = 2'b11
  } state_e;

  function automatic logic addr_in_range(input logic is_dcache, input logic [ADDR_W-1:0] addr);
    int lim;
    lim = is_dcache ? DMEM_SZ : IMEM_SZ;
    return int'(addr) < lim;
  endfunction

endpackage

// File: rtl/spi_frame_deser.sv
// MSB-first frame deserialiser: shift register, mod-FRAME_W bit counter and a
// combinational frame_done flag for the cycle that samples the last bit.
module spi_frame_deser
  import spi_load_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en_i,
  input  logic               clr_i,
  input  logic               mosi_i,
  output logic [CNT_W-1:0]   bit_cnt_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_done_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  logic [FRAME_W-2:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // The completed frame includes the bit being sampled this cycle.
  assign frame_o      = {sreg_q, mosi_i};
  assign frame_done_o = shift_en_i && !clr_i && (cnt_q == LAST_BIT);
  assign bit_cnt_o    = cnt_q;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (shift_en_i) begin
      sreg_d = frame_o[FRAME_W-2:0];
      cnt_d  = (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_load_sequencer.sv
// SPI-slave cache loader: select arbitration FSM, one-cycle commit strobes with
// range check, sticky error flags and the per-load committed frame counter.
module spi_load_sequencer
  import spi_load_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mosi_in,
  input  logic              csi_n_in,
  input  logic              csd_n_in,
  input  logic              err_clr_in,
  output logic              icache_wen_out,
  output logic              dcache_wen_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              load_busy_out,
  output logic              frame_err_out,
  output logic              addr_err_out,
  output logic [FCNT_W-1:0] frame_cnt_out
);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               pend_q, pend_d;
  logic               tgt_q, tgt_d;
  logic               frame_err_q, frame_err_d;
  logic               addr_err_q, addr_err_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic               shift_en, deser_clr, fe_set, cnt_clr, commit_ok;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] frame_next;
  logic               frame_done;

  spi_frame_deser u_deser (
    .clk          (clk),
    .rst          (rst),
    .shift_en_i   (shift_en),
    .clr_i        (deser_clr),
    .mosi_i       (mosi_in),
    .bit_cnt_o    (bit_cnt),
    .frame_o      (frame_next),
    .frame_done_o (frame_done)
  );

  assign commit_ok = pend_q && addr_in_range(tgt_q, hold_q[ADDR_W-1:0]);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    pend_d      = 1'b0;
    tgt_d       = tgt_q;
    frame_err_d = frame_err_q && !err_clr_in;
    addr_err_d  = addr_err_q && !err_clr_in;
    frame_cnt_d = frame_cnt_q;
    shift_en    = 1'b0;
    deser_clr   = 1'b0;
    fe_set      = 1'b0;
    cnt_clr     = 1'b0;

    if (pend_q) begin
      if (commit_ok) begin
        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end else begin
        addr_err_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!csi_n_in && csd_n_in) begin
          state_d  = ST_SHIFT_I;
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
        end else if (csi_n_in && !csd_n_in) begin
          state_d  = ST_SHIFT_D;
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
        end else if (!csi_n_in && !csd_n_in) begin
          state_d = ST_ABORT;
          fe_set  = 1'b1;
        end
      end
      ST_SHIFT_I, ST_SHIFT_D: begin
        // Conflict takes priority over a simultaneous deselect of the own select.
        if ((state_q == ST_SHIFT_I) ? !csd_n_in : !csi_n_in) begin
          state_d   = ST_ABORT;
          fe_set    = 1'b1;
          deser_clr = 1'b1;
        end else if ((state_q == ST_SHIFT_I) ? csi_n_in : csd_n_in) begin
          state_d   = ST_IDLE;
          fe_set    = (bit_cnt != '0);
          deser_clr = 1'b1;
        end else begin
          shift_en = 1'b1;
        end
      end
      ST_ABORT: begin
        deser_clr = 1'b1;
        if (csi_n_in && csd_n_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_done) begin
      hold_d = frame_next;
      pend_d = 1'b1;
      tgt_d  = (state_q == ST_SHIFT_D);
    end
    // A new load restarts the count even if an older commit lands this cycle.
    if (cnt_clr) frame_cnt_d = '0;
    if (fe_set)  frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      pend_q      <= 1'b0;
      tgt_q       <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      tgt_q       <= tgt_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign icache_wen_out = commit_ok && !tgt_q;
  assign dcache_wen_out = commit_ok && tgt_q;
  assign wr_addr_out    = hold_q[ADDR_W-1:0];
  assign wr_data_out    = hold_q[FRAME_W-1:ADDR_W];
  assign load_busy_out  = (state_q != ST_IDLE) || pend_q;
  assign frame_err_out  = frame_err_q;
  assign addr_err_out   = addr_err_q;
  assign frame_cnt_out  = frame_cnt_q;

endmodule

// File: tb/tb_spi_load_sequencer.sv
// Self-checking bench for spi_load_sequencer: scenario tasks compare observed cache
// strobes and status outputs against a frame-level reference model.
module tb_spi_load_sequencer;
  import spi_load_sequencer_pkg::*;

  typedef struct packed {
    logic [31:0] cyc;
    logic        dc;
    logic [3:0]  a;
    logic [7:0]  d;
  } ev_t;

  logic clk = 1'b0;
  logic rst, mosi_in, csi_n_in, csd_n_in, err_clr_in;
  logic icache_wen_out, dcache_wen_out, load_busy_out, frame_err_out, addr_err_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [DATA_W-1:0] wr_data_out;
  logic [FCNT_W-1:0] frame_cnt_out;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];
  bit  both_seen = 0;
  bit  sel_on    = 0;
  int  m_cnt     = 0;
  bit  m_aerr    = 0;

  spi_load_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .mosi_in        (mosi_in),
    .csi_n_in       (csi_n_in),
    .csd_n_in       (csd_n_in),
    .err_clr_in     (err_clr_in),
    .icache_wen_out (icache_wen_out),
    .dcache_wen_out (dcache_wen_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .load_busy_out  (load_busy_out),
    .frame_err_out  (frame_err_out),
    .addr_err_out   (addr_err_out),
    .frame_cnt_out  (frame_cnt_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (icache_wen_out && dcache_wen_out) both_seen = 1;
      if (icache_wen_out || dcache_wen_out)
        obs_q.push_back({32'(cyc), dcache_wen_out, wr_addr_out, wr_data_out});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    csi_n_in = 1'b1;
    csd_n_in = 1'b1;
    mosi_in  = 1'b0;
    repeat (n) tick();
    sel_on = 0;
  endtask

  // Drives one full frame; the model records the expected commit or address error.
  task automatic send_frame(bit dc, logic [3:0] a, logic [7:0] d);
    logic [11:0] f;
    f = {d, a};
    if (!sel_on) m_cnt = 0;
    sel_on = 1;
    for (int b = 11; b >= 0; b--) begin
      csi_n_in = dc;
      csd_n_in = !dc;
      mosi_in  = f[b];
      tick();
    end
    if (int'(a) < (dc ? DMEM_SZ : IMEM_SZ)) begin
      exp_q.push_back({32'(cyc), dc, a, d});
      if (m_cnt < 31) m_cnt++;
    end else begin
      m_aerr = 1;
    end
  endtask

  task automatic pulse_clr();
    err_clr_in = 1'b1;
    tick();
    err_clr_in = 1'b0;
    m_aerr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mosi_in = 1'b0; csi_n_in = 1'b1; csd_n_in = 1'b1; err_clr_in = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({icache_wen_out, dcache_wen_out, load_busy_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {icache_wen_out, dcache_wen_out, load_busy_out});
    end
    n_tests++;
    if ({wr_addr_out, wr_data_out, frame_cnt_out} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%0d want 0", wr_addr_out, wr_data_out, frame_cnt_out);
    end
    n_tests++;
    if ({frame_err_out, addr_err_out} !== 2'b00) begin
      n_fail++; $display("FAIL reset_err: got %b want 00", {frame_err_out, addr_err_out});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_iframe();
    obs_q.delete(); exp_q.delete();
    send_frame(0, 4'h3, 8'hA5);
    idle(3);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_n: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (int'(frame_cnt_out) !== m_cnt) begin
      n_fail++; $display("FAIL single_cnt: got %0d want %0d", frame_cnt_out, m_cnt);
    end
    n_tests++;
    if (load_busy_out !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: got %b want 0", load_busy_out);
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 3; k++) send_frame(1, 4'(k), 8'($urandom));
    idle(3);
    n_tests++;
    if (obs_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_n: got %0d strobes want 3", obs_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (frame_cnt_out !== 5'd3) begin
      n_fail++; $display("FAIL b2b_cnt: got %0d want 3", frame_cnt_out);
    end
  endtask

  task automatic test_range();
    obs_q.delete(); exp_q.delete();
    send_frame(1, 4'd9, 8'($urandom));
    idle(2);
    n_tests++;
    if (addr_err_out !== 1'b1 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL range_d9: got err=%b strobes=%0d want err=1 strobes=0", addr_err_out, obs_q.size());
    end
    send_frame(1, 4'd8, 8'($urandom));
    idle(1);
    send_frame(0, 4'd9, 8'($urandom));
    idle(3);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL range_n: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL range_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    pulse_clr();
    n_tests++;
    if (addr_err_out !== 1'b0) begin
      n_fail++; $display("FAIL range_clr: got %b want 0", addr_err_out);
    end
  endtask

  task automatic test_truncation();
    obs_q.delete();
    for (int b = 0; b < 7; b++) begin
      csi_n_in = 1'b0; csd_n_in = 1'b1; mosi_in = 1'($urandom); tick();
    end
    csi_n_in = 1'b1;
    err_clr_in = 1'b1;
    tick();
    err_clr_in = 1'b0;
    idle(2);
    n_tests++;
    if (frame_err_out !== 1'b1) begin
      n_fail++; $display("FAIL trunc_err_setwins: got %b want 1", frame_err_out);
    end
    n_tests++;
    if (load_busy_out !== 1'b0 || obs_q.size() != 0 || frame_cnt_out !== 5'd0) begin
      n_fail++; $display("FAIL trunc_idle: got busy=%b strobes=%0d cnt=%0d want 0/0/0", load_busy_out, obs_q.size(), frame_cnt_out);
    end
    pulse_clr();
    n_tests++;
    if (frame_err_out !== 1'b0) begin
      n_fail++; $display("FAIL trunc_clr: got %b want 0", frame_err_out);
    end
  endtask

  task automatic test_conflict();
    obs_q.delete();
    for (int b = 0; b < 5; b++) begin
      csi_n_in = 1'b0; csd_n_in = 1'b1; mosi_in = 1'($urandom); tick();
    end
    csd_n_in = 1'b0;
    tick();
    n_tests++;
    if (frame_err_out !== 1'b1 || load_busy_out !== 1'b1) begin
      n_fail++; $display("FAIL conflict_abort: got err=%b busy=%b want 1/1", frame_err_out, load_busy_out);
    end
    for (int k = 0; k < 14; k++) begin
      mosi_in = 1'($urandom); tick();
    end
    csi_n_in = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (load_busy_out !== 1'b1) begin
      n_fail++; $display("FAIL conflict_hold: got busy=%b want 1", load_busy_out);
    end
    csd_n_in = 1'b1;
    tick();
    n_tests++;
    if (load_busy_out !== 1'b0 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL conflict_exit: got busy=%b strobes=%0d want 0/0", load_busy_out, obs_q.size());
    end
    idle(1);
    pulse_clr();
  endtask

  task automatic test_saturation();
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 33; k++) send_frame(0, 4'($urandom), 8'($urandom));
    idle(3);
    n_tests++;
    if (frame_cnt_out !== 5'd31 || obs_q.size() != 33) begin
      n_fail++; $display("FAIL sat: got cnt=%0d strobes=%0d want 31/33", frame_cnt_out, obs_q.size());
    end
  endtask

  task automatic test_random();
    bit prev_dc, dc;
    obs_q.delete(); exp_q.delete(); both_seen = 0;
    prev_dc = 0;
    for (int k = 0; k < 24; k++) begin
      dc = 1'($urandom);
      if (k > 0 && (dc != prev_dc || $urandom_range(2) == 0)) idle(1 + $urandom_range(1));
      send_frame(dc, 4'($urandom), 8'($urandom));
      prev_dc = dc;
    end
    idle(3);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_n: got %0d strobes want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (int'(frame_cnt_out) !== m_cnt || addr_err_out !== m_aerr || frame_err_out !== 1'b0) begin
      n_fail++; $display("FAIL rand_status: got cnt=%0d aerr=%b ferr=%b want %0d/%b/0", frame_cnt_out, addr_err_out, frame_err_out, m_cnt, m_aerr);
    end
    n_tests++;
    if (both_seen !== 1'b0) begin
      n_fail++; $display("FAIL rand_excl: got both strobes high want never");
    end
    pulse_clr();
  endtask

  task automatic test_async_reset();
    obs_q.delete(); exp_q.delete();
    send_frame(0, 4'h7, 8'h5A);
    for (int b = 0; b < 6; b++) begin
      csi_n_in = 1'b0; mosi_in = 1'($urandom); tick();
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({icache_wen_out, dcache_wen_out, load_busy_out, frame_err_out, addr_err_out} !== 5'b0) begin
      n_fail++; $display("FAIL arst_ctrl: got %b want 00000", {icache_wen_out, dcache_wen_out, load_busy_out, frame_err_out, addr_err_out});
    end
    n_tests++;
    if ({wr_addr_out, wr_data_out, frame_cnt_out} !== '0) begin
      n_fail++; $display("FAIL arst_data: got %h/%h/%0d want 0", wr_addr_out, wr_data_out, frame_cnt_out);
    end
    csi_n_in = 1'b1; csd_n_in = 1'b1;
    tick();
    rst = 1'b0;
    idle(14);
    m_cnt = 0; m_aerr = 0;
    n_tests++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
      n_fail++; $display("FAIL arst_nostrobe: got %0d strobes want only the pre-reset one", obs_q.size());
    end
    send_frame(1, 4'h2, 8'hC3);
    idle(3);
    n_tests++;
    if (obs_q.size() != 2 || (obs_q.size() == 2 && obs_q[1] !== exp_q[1]) || frame_cnt_out !== 5'd1) begin
      n_fail++; $display("FAIL arst_fresh: got strobes=%0d cnt=%0d want 2/1", obs_q.size(), frame_cnt_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_iframe();
    test_back_to_back();
    test_range();
    test_truncation();
    test_conflict();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
